// File: rtl/conv2_window_buf_if.sv
// Stream bundle between the pool1 output, the conv2 window buffer and the
// conv2 XNOR/popcount calculator.
//
// Handshake: valid-only, no ready. A pixel is transferred on every rising clk
// edge where valid_in=1. A window is presented for exactly the cycle where
// valid_out_buf=1. The consumer must take it in that cycle because nothing
// stalls. pixel_windows holds its value on cycles with valid_out_buf=0.
interface conv2_window_buf_if #(
  parameter int NUM_CH = 8
);
  logic                  valid_in;
  logic [NUM_CH-1:0]     pixel_in;
  logic [9*NUM_CH-1:0]   pixel_windows;
  logic                  valid_out_buf;
  logic                  frame_done;

  // Producer side: drives pixels and observes windows.
  modport master (
    output valid_in,
    output pixel_in,
    input  pixel_windows,
    input  valid_out_buf,
    input  frame_done
  );

  // Window buffer side: accepts pixels and produces windows.
  modport slave (
    input  valid_in,
    input  pixel_in,
    output pixel_windows,
    output valid_out_buf,
    output frame_done
  );
endinterface

// File: rtl/conv2_window_buf.sv
// Two-line buffer plus 3x3 shift window for the conv2 stage. Raster pixels of
// NUM_CH binary channels come in, and every full 3x3xNUM_CH neighbourhood goes
// out as one registered word. Bit ch*9 + wr*3 + wc holds channel ch at window
// row wr and window column wc. Row 0 and column 0 are the oldest.
module conv2_window_buf #(
  parameter int IMG_W  = 13,
  parameter int IMG_H  = 13,
  parameter int NUM_CH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  conv2_window_buf_if.slave   bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WIN_W = 9 * NUM_CH;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Raster position of the pixel being accepted this cycle.
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // Line buffers. lb_top holds row r-2 and lb_mid holds row r-1 at each column.
  logic [NUM_CH-1:0] lb_top [IMG_W];
  logic [NUM_CH-1:0] lb_mid [IMG_W];

  // Window shift register. Index 0 is column c-2 and index 2 is column c.
  logic [NUM_CH-1:0] w_top [3];
  logic [NUM_CH-1:0] w_mid [3];
  logic [NUM_CH-1:0] w_bot [3];

  // Window contents after this cycle's shift, used for both update and output.
  logic [NUM_CH-1:0] n_top [3];
  logic [NUM_CH-1:0] n_mid [3];
  logic [NUM_CH-1:0] n_bot [3];
  logic [WIN_W-1:0]  win_next;

  logic accept;
  logic col_wrap;
  logic frame_wrap;
  logic emit;

  // Reset is handled inside every state block, so it also overrides a
  // coincident valid_in.
  assign accept     = bus.valid_in;
  assign col_wrap   = (col == COL_LAST);
  assign frame_wrap = col_wrap && (row == ROW_LAST);
  // Only positions with two full rows and two full columns behind them form a
  // window. Columns 0 and 1 of each row just refill the shift register.
  assign emit       = accept && (row >= ROW_TWO) && (col >= COL_TWO);

  // Raster counters advance once per accepted pixel and wrap at frame end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col <= '0;
        row <= frame_wrap ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers age one row per accept. They need no reset because rows 0
  // and 1 are rewritten before any window can be emitted.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      lb_top[col] <= lb_mid[col];
      lb_mid[col] <= bus.pixel_in;
    end
  end

  // Next window: shift left by one column and append the new column, formed
  // from the two line buffers and the incoming pixel.
  always_comb begin
    n_top[0] = w_top[1];
    n_top[1] = w_top[2];
    n_top[2] = lb_top[col];
    n_mid[0] = w_mid[1];
    n_mid[1] = w_mid[2];
    n_mid[2] = lb_mid[col];
    n_bot[0] = w_bot[1];
    n_bot[1] = w_bot[2];
    n_bot[2] = bus.pixel_in;
  end

  // Pack the next window channel-major with 9 row-major bits per channel.
  always_comb begin
    win_next = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int wc = 0; wc < 3; wc++) begin
        win_next[ch*9 + 0 + wc] = n_top[wc][ch];
        win_next[ch*9 + 3 + wc] = n_mid[wc][ch];
        win_next[ch*9 + 6 + wc] = n_bot[wc][ch];
      end
    end
  end

  // The window shift register moves on every accept, including columns 0 and
  // 1 where no window is emitted.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      for (int i = 0; i < 3; i++) begin
        w_top[i] <= n_top[i];
        w_mid[i] <= n_mid[i];
        w_bot[i] <= n_bot[i];
      end
    end
  end

  // Output register: one-cycle pulses, and the window holds between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.valid_out_buf <= 1'b0;
      bus.frame_done    <= 1'b0;
      bus.pixel_windows <= '0;
    end else begin
      bus.valid_out_buf <= emit;
      bus.frame_done    <= emit && frame_wrap;
      if (emit) begin
        bus.pixel_windows <= win_next;
      end
    end
  end

endmodule

// File: tb/tb_conv2_window_buf.sv
// Bench for conv2_window_buf. Driver tasks stream raster frames from an image
// array. Expected windows are cut straight out of that image and queued with
// their due cycle. A negedge monitor pops and compares every emitted window
// and checks that outputs hold on idle cycles and clear during reset.
module tb_conv2_window_buf;

  localparam int W  = 13;
  localparam int H  = 13;
  localparam int C  = 8;
  localparam int WW = 9 * C;
  localparam int WIN_PER_FRAME = (H - 2) * (W - 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  conv2_window_buf_if #(.NUM_CH(C)) bus ();

  conv2_window_buf #(.IMG_W(W), .IMG_H(H), .NUM_CH(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  bit rst_seen = 1'b0;
  bit armed = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_seen = !rst_n;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference image and scoreboard ----------------
  logic [C-1:0]  img [H][W];
  logic [WW:0]   exp_q[$];      // {frame_done, window}
  int            exp_cyc_q[$];  // cycle in which the window must appear
  logic [WW-1:0] last_win = '0;
  logic [WW-1:0] first_win;
  int            capture_at = -1;
  int            pulse_cnt = 0;
  int            fd_cnt = 0;
  int            errors = 0;
  int            checks = 0;

  // Window whose bottom-right pixel is (r, c), taken directly from the image.
  function automatic logic [WW-1:0] ref_window(input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int ch = 0; ch < C; ch++)
      for (int wr = 0; wr < 3; wr++)
        for (int wc = 0; wc < 3; wc++)
          w[ch*9 + wr*3 + wc] = img[r-2+wr][c-2+wc][ch];
    return w;
  endfunction

  task automatic check_vec(input string name, input logic [WW+1:0] act, input logic [WW+1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d required %0d", name, cyc, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [WW:0] e;
    int ec;
    if (rst_seen) begin
      armed = 1'b1;
      last_win = '0;
      check_vec("reset_outputs", {bus.valid_out_buf, bus.frame_done, bus.pixel_windows}, '0);
    end else if (bus.valid_out_buf) begin
      pulse_cnt++;
      if (bus.frame_done) fd_cnt++;
      if (pulse_cnt == capture_at) first_win = bus.pixel_windows;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window at cycle %0d: got valid_out_buf=1 required 0", cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check_vec("window", {1'b1, bus.frame_done, bus.pixel_windows}, {1'b1, e});
        check_int("latency", cyc, ec);
        last_win = e[WW-1:0];
      end
    end else if (armed) begin
      check_vec("idle_hold", {1'b0, bus.frame_done, bus.pixel_windows}, {2'b00, last_win});
    end
  end

  // ---------------- image fill ----------------
  task automatic fill_zero();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = '0;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = C'((r*13 + c) & 255);
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = C'($urandom);
  endtask

  // ---------------- driver tasks ----------------
  // Stream the first n_acc raster pixels of img with the given valid duty (%).
  task automatic drive_frame(input int n_acc, input int duty);
    int k;
    int r;
    int c;
    k = 0;
    while (k < n_acc) begin
      @(posedge clk); #1;
      if (int'($urandom_range(99)) < duty) begin
        r = k / W;
        c = k % W;
        bus.valid_in = 1'b1;
        bus.pixel_in = img[r][c];
        if (r >= 2 && c >= 2) begin
          exp_q.push_back({(r == H-1 && c == W-1), ref_window(r, c)});
          exp_cyc_q.push_back(cyc + 1);
        end
        k++;
      end else begin
        bus.valid_in = 1'b0;
        bus.pixel_in = C'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      bus.pixel_in = C'($urandom);
    end
  endtask

  // Hold reset for n edges with random traffic that must be ignored.
  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      bus.valid_in = 1'($urandom_range(1));
      bus.pixel_in = C'($urandom);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    bus.valid_in = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    idle(2);
    while (exp_q.size() > 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_int(name, exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int p0;
    int f0;
    bus.valid_in = 1'b0;
    bus.pixel_in = '0;

    // Reset with random traffic.
    apply_reset(3);
    idle(2);

    // Bit mapping of the first window.
    fill_zero();
    img[0][0] = 8'h01;
    img[2][2] = 8'h80;
    p0 = pulse_cnt; f0 = fd_cnt;
    capture_at = pulse_cnt + 1;
    drive_frame(W*H, 100);
    drain("drain_bitmap");
    check_vec("first_window_bits", {2'b00, first_win}, {2'b00, 72'h80_0000_0000_0000_0001});
    check_int("pulses_bitmap", pulse_cnt - p0, WIN_PER_FRAME);
    check_int("frame_done_bitmap", fd_cnt - f0, 1);

    // Ramp frame with continuous valid.
    fill_ramp();
    p0 = pulse_cnt; f0 = fd_cnt;
    drive_frame(W*H, 100);
    drain("drain_ramp");
    check_int("pulses_ramp", pulse_cnt - p0, WIN_PER_FRAME);
    check_int("frame_done_ramp", fd_cnt - f0, 1);

    // Same ramp with about 50% valid duty.
    p0 = pulse_cnt; f0 = fd_cnt;
    drive_frame(W*H, 50);
    drain("drain_gaps");
    check_int("pulses_gaps", pulse_cnt - p0, WIN_PER_FRAME);
    check_int("frame_done_gaps", fd_cnt - f0, 1);

    // Two back-to-back frames with different content.
    p0 = pulse_cnt; f0 = fd_cnt;
    fill_random();
    drive_frame(W*H, 100);
    fill_ramp();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = ~img[r][c];
    drive_frame(W*H, 100);
    drain("drain_b2b");
    check_int("pulses_b2b", pulse_cnt - p0, 2*WIN_PER_FRAME);
    check_int("frame_done_b2b", fd_cnt - f0, 2);

    // Abort a frame after 100 accepts, reset, then run a fresh frame.
    fill_random();
    drive_frame(100, 100);
    idle(1);
    drain("drain_abort");
    apply_reset(2);
    fill_random();
    p0 = pulse_cnt; f0 = fd_cnt;
    drive_frame(W*H, 70);
    drain("drain_after_reset");
    check_int("pulses_after_reset", pulse_cnt - p0, WIN_PER_FRAME);
    check_int("frame_done_after_reset", fd_cnt - f0, 1);

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
